reg_write_arbiter: RTL and testbench

- Shares one load-enabled `Register` (its `ld`/`D` inputs) among `NREQ` requesters using round-robin arbitration with bounded bursts.
- Requesters include datapath units that write a common status/holding register.
- The block drives the register's `ld` and `D` from flops. Each write the register captures corresponds to exactly one sampled, granted request.
- It sits beside the shared `Register` instance in the processor top level.

---
 rtl/reg_write_arbiter_pkg.sv | 30 +++
 rtl/reg_write_arbiter_rr_select.sv | 40 ++++
 rtl/reg_write_arbiter.sv | 123 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/reg_write_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : reg_write_arbiter_pkg
// Brief    : State encoding and width helper shared by the write arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package reg_write_arbiter_pkg;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = S_IDLE,
        ST_GRANT = S_GRANT
    } state_t;

    // Bits needed to index 'value' distinct items; never less than one bit.
    function automatic int clog2_w(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_write_arbiter_rr_select.sv
//------------------------------------------------------------------------------
// Module   : reg_write_arbiter_rr_select
// Brief    : Combinational round-robin pick: first request at or after ptr.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_write_arbiter_rr_select
    import reg_write_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  win,
    output logic             any
);

    logic w_found;
    int   w_idx;

    always_comb begin
        win     = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(ptr) + k) % NREQ;
            if (!w_found && req[w_idx]) begin
                win[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
//------------------------------------------------------------------------------
// Module   : reg_write_arbiter
// Brief    : Round-robin, burst-limited arbiter driving a shared register's ld/D.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N         = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ*N-1:0] data,
    output logic [NREQ-1:0] gnt,
    output logic            ld,
    output logic [N-1:0]    D,
    output logic            busy
);

    localparam int                C_PTR_W    = clog2_w(NREQ);
    localparam int                C_CNT_W    = clog2_w(MAX_BURST + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(MAX_BURST);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);
    localparam logic [C_PTR_W-1:0] C_PTR_LAST = C_PTR_W'(NREQ - 1);

    state_t               r_state, w_state_nx;
    logic [C_PTR_W-1:0]   r_ptr, w_ptr_nx;
    logic [C_CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic [C_PTR_W-1:0]   r_owner, w_owner_nx;
    logic [NREQ-1:0]      r_gnt, w_gnt_nx;
    logic                 r_ld, w_ld_nx;
    logic [N-1:0]         r_d, w_d_nx;

    logic [NREQ-1:0]      w_win;
    logic                 w_any;
    logic [C_PTR_W-1:0]   w_win_idx;
    logic                 w_keep;

    reg_write_arbiter_rr_select #(
        .NREQ  (NREQ),
        .PTR_W (C_PTR_W)
    ) u_rr_select (
        .req (req),
        .ptr (r_ptr),
        .win (w_win),
        .any (w_any)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win[i]) begin
                w_win_idx = C_PTR_W'(i);
            end
        end
    end

    // The owner keeps the register only while it still requests and has burst left.
    assign w_keep = (r_state == ST_GRANT) && req[r_owner] && (r_cnt < C_CNT_MAX);

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_cnt_nx   = r_cnt;
        w_owner_nx = r_owner;
        w_gnt_nx   = '0;
        w_ld_nx    = 1'b0;
        w_d_nx     = r_d;
        if (w_keep) begin
            w_state_nx = ST_GRANT;
            w_cnt_nx   = r_cnt + C_CNT_ONE;
            w_gnt_nx   = r_gnt;
            w_ld_nx    = 1'b1;
            w_d_nx     = data[int'(r_owner)*N +: N];
        end else if (w_any) begin
            // New grant; an expired sole requester wraps back to itself here.
            w_state_nx = ST_GRANT;
            w_owner_nx = w_win_idx;
            w_ptr_nx   = (w_win_idx == C_PTR_LAST) ? '0 : w_win_idx + C_PTR_ONE;
            w_cnt_nx   = C_CNT_ONE;
            w_gnt_nx   = w_win;
            w_ld_nx    = 1'b1;
            w_d_nx     = data[int'(w_win_idx)*N +: N];
        end else begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_owner <= '0;
            r_gnt   <= '0;
            r_ld    <= 1'b0;
            r_d     <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_cnt   <= w_cnt_nx;
            r_owner <= w_owner_nx;
            r_gnt   <= w_gnt_nx;
            r_ld    <= w_ld_nx;
            r_d     <= w_d_nx;
        end
    end

    assign gnt  = r_gnt;
    assign ld   = r_ld;
    assign D    = r_d;
    assign busy = (r_state == ST_GRANT);

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_reg_write_arbiter
// Brief    : Directed self-checking bench for reg_write_arbiter (N=8, NREQ=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_write_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        ld;
    logic [7:0]  D;
    logic        busy;
    logic [7:0]  r_shared;

    int n_checks = 0;
    int n_pass   = 0;

    reg_write_arbiter #(
        .N         (8),
        .NREQ      (4),
        .MAX_BURST (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .data (data),
        .gnt  (gnt),
        .ld   (ld),
        .D    (D),
        .busy (busy)
    );

    // Stand-in for the shared load-enabled register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     r_shared <= 8'h00;
        else if (ld) r_shared <= D;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        data = '0;
        #2;
        rst  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        req  = 4'b1111;
        data = '0;
        #12;
        check("rst_gnt",  gnt,  4'b0000);
        check("rst_ld",   ld,   1'b0);
        check("rst_D",    D,    8'h00);
        check("rst_busy", busy, 1'b0);

        req = 4'b0001;
        data[7:0] = 8'hA5;
        rst = 1'b0;
        step();
        check("first_gnt",  gnt,  4'b0001);
        check("first_ld",   ld,   1'b1);
        check("first_D",    D,    8'hA5);
        check("first_busy", busy, 1'b1);
        req = 4'b0000;
        step();
        check("first_reg", r_shared, 8'hA5);
        check("first_idle_ld", ld, 1'b0);

        // Round robin: owner drops its request after every grant
        do_reset();
        req = 4'b1111; step(); check("rr0", gnt, 4'b0001);
        req = 4'b1110; step(); check("rr1", gnt, 4'b0010);
        req = 4'b1101; step(); check("rr2", gnt, 4'b0100);
        req = 4'b1011; step(); check("rr3", gnt, 4'b1000);
        req = 4'b0111; step(); check("rr4", gnt, 4'b0001);

        // Burst limit with changing data
        do_reset();
        req = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            data[7:0] = 8'h10 + 8'(c);
            step();
            check("burst_gnt", gnt, 4'b0001);
            check("burst_ld",  ld,  1'b1);
            check("burst_D",   D,   32'(8'h10 + 8'(c)));
        end
        data[7:0]  = 8'h14;
        data[15:8] = 8'h55;
        step();
        check("burst_hand_gnt", gnt, 4'b0010);
        check("burst_hand_ld",  ld,  1'b1);
        check("burst_hand_D",   D,   8'h55);

        // Sole requester re-granted across expiries
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 9; c++) begin
            data[23:16] = 8'h30 + 8'(c);
            step();
            check("sole_gnt_ld", {gnt, ld}, {4'b0100, 1'b1});
            check("sole_D", D, 32'(8'h30 + 8'(c)));
        end

        // Release then idle, then a fresh request
        do_reset();
        req = 4'b0100;
        data[23:16] = 8'h21;
        step(); check("rel_ld1", ld, 1'b1);
        data[23:16] = 8'h22;
        step(); check("rel_ld2", ld, 1'b1);
        req = 4'b0000;
        step();
        check("rel_gnt",  gnt,  4'b0000);
        check("rel_busy", busy, 1'b0);
        check("rel_ld",   ld,   1'b0);
        check("rel_Dhold", D,   8'h22);
        step(); check("rel_ld_idle", ld, 1'b0);
        req = 4'b1000;
        data[31:24] = 8'h77;
        step();
        check("late_gnt", gnt, 4'b1000);
        check("late_D",   D,   8'h77);

        // Async reset in the middle of a burst
        do_reset();
        req = 4'b0010;
        data[15:8] = 8'h5A;
        step(); step(); step();
        check("mid_pre_gnt", gnt, 4'b0010);
        #2;
        rst = 1'b1;
        #1;
        check("mid_ld",   ld,   1'b0);
        check("mid_gnt",  gnt,  4'b0000);
        check("mid_D",    D,    8'h00);
        check("mid_busy", busy, 1'b0);
        req = 4'b1111;
        #2;
        rst = 1'b0;
        step(); check("mid_order0", gnt, 4'b0001);
        req = 4'b1110;
        step(); check("mid_order1", gnt, 4'b0010);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
